// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, credit-count width helper and the
// link occupancy states used for debug visibility.
package noc_pkg;

    localparam int FLIT_WIDTH      = 32;
    localparam int DEFAULT_CREDITS = 3;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        PARTIAL   = 2'd1,
        EXHAUSTED = 2'd2
    } link_state_t;

    // Width needed to hold every value 0..credits inclusive.
    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    localparam int CREDIT_W = credit_width(DEFAULT_CREDITS);

    function automatic link_state_t link_state_of(input int count, input int credits);
        if (count == credits) return FREE;
        if (count == 0)       return EXHAUSTED;
        return PARTIAL;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter. Starts full; an increment while already
// full saturates and latches a sticky overflow error until reset.
module credit_counter
    import noc_pkg::*;
#(
    parameter int MAX = DEFAULT_CREDITS,
    parameter int W   = credit_width(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero,
    output logic         o_overflow_err
);

    logic [W-1:0] r_count;
    logic         r_err;
    logic         w_at_max;

    assign w_at_max = (r_count == W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= W'(MAX);
            r_err   <= 1'b0;
        end else begin
            case ({i_inc, i_dec})
                2'b10: begin
                    if (w_at_max) r_err <= 1'b1;
                    else          r_count <= r_count + W'(1);
                end
                // Underflow guard; the owner never decrements at zero.
                2'b01: begin
                    if (r_count != '0) r_count <= r_count - W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_count        = r_count;
    assign o_zero         = (r_count == '0);
    assign o_overflow_err = r_err;

endmodule

// File: rtl/link_credit_tx.sv
// Credit-based link transmitter: accepts flits by valid/ready and registers
// them onto the link only while the downstream FIFO has a free slot.
module link_credit_tx
    import noc_pkg::*;
#(
    parameter  int DATA_WIDTH = FLIT_WIDTH,
    parameter  int CREDITS    = DEFAULT_CREDITS,
    localparam int CW         = credit_width(CREDITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    input  logic                  credit_return,
    output logic [CW-1:0]         credits,
    output logic                  stalled,
    output logic                  credit_err
);

    // Handshake: a flit transfers on any rising edge where in_valid and
    // in_ready are both high; in_ready depends only on the registered count.
    logic                  w_zero;
    logic                  w_send;
    logic                  r_link_valid;
    logic [DATA_WIDTH-1:0] r_link_data;

    assign in_ready = ~w_zero;
    assign w_send   = in_valid & in_ready;
    assign stalled  = in_valid & ~in_ready;

    credit_counter #(
        .MAX (CREDITS),
        .W   (CW)
    ) u_credit_counter (
        .clk            (clk),
        .reset          (reset),
        .i_inc          (credit_return),
        .i_dec          (w_send),
        .o_count        (credits),
        .o_zero         (w_zero),
        .o_overflow_err (credit_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
        end else begin
            r_link_valid <= w_send;
            if (w_send) r_link_data <= in_data;
        end
    end

    assign link_valid = r_link_valid;
    assign link_data  = r_link_data;

endmodule

// File: tb/tb_link_credit_tx.sv
// Directed bench for link_credit_tx with a credit-accounting reference model
// compared against the DUT every cycle, plus literal expectations.
module tb_link_credit_tx;

    localparam int DW  = 32;
    localparam int CR  = 3;
    localparam int CW  = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic          credit_return = 1'b0;
    logic [CW-1:0] credits;
    logic          stalled;
    logic          credit_err;

    int n_checks = 0;
    int n_errors = 0;

    link_credit_tx #(.DATA_WIDTH(DW), .CREDITS(CR)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .link_valid    (link_valid),
        .link_data     (link_data),
        .credit_return (credit_return),
        .credits       (credits),
        .stalled       (stalled),
        .credit_err    (credit_err)
    );

    // clock/reset
    always #5 clk = ~clk;

    // reference model: free slots downstream, last flit put on the link
    int            m_credits = CR;
    bit            m_err = 1'b0;
    bit            m_lv = 1'b0;
    logic [DW-1:0] m_ld = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_credits = CR;
            m_err     = 1'b0;
            m_lv      = 1'b0;
            m_ld      = '0;
        end else begin
            bit s;
            s = in_valid && (m_credits > 0);
            m_credits = m_credits - (s ? 1 : 0) + (credit_return ? 1 : 0);
            if (m_credits > CR) begin
                m_credits = CR;
                m_err     = 1'b1;
            end
            m_lv = s;
            if (s) m_ld = in_data;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle compare against the model
    always @(negedge clk) begin
        check("m_credits",    DW'(credits),    DW'(m_credits));
        check("m_in_ready",   DW'(in_ready),   DW'(m_credits != 0));
        check("m_stalled",    DW'(stalled),    DW'(in_valid && m_credits == 0));
        check("m_link_valid", DW'(link_valid), DW'(m_lv));
        check("m_link_data",  link_data,       m_ld);
        check("m_credit_err", DW'(credit_err), DW'(m_err));
    end

    // driver: present inputs, then sample 1ns after the edge that consumes them
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r);
        @(negedge clk);
        #2;
        in_valid      = v;
        in_data       = d;
        credit_return = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;

        cycle(0, '0, 0);
        check("rst_credits",  DW'(credits),    DW'(3));
        check("rst_in_ready", DW'(in_ready),   DW'(1));
        check("rst_lv",       DW'(link_valid), DW'(0));
        check("rst_ld",       link_data,       DW'(0));
        check("rst_err",      DW'(credit_err), DW'(0));

        cycle(1, 32'hA0A0_0001, 0);
        check("a_lv", DW'(link_valid), DW'(1));
        check("a_ld", link_data, 32'hA0A0_0001);
        check("a_cr", DW'(credits), DW'(2));
        cycle(1, 32'hB0B0_0002, 0);
        check("b_ld", link_data, 32'hB0B0_0002);
        check("b_cr", DW'(credits), DW'(1));
        cycle(1, 32'hC0C0_0003, 0);
        check("c_ld", link_data, 32'hC0C0_0003);
        check("c_cr", DW'(credits), DW'(0));
        check("c_rdy", DW'(in_ready), DW'(0));
        cycle(1, 32'hD0D0_0004, 0);
        check("d_held_lv", DW'(link_valid), DW'(0));
        check("d_held_ld", link_data, 32'hC0C0_0003);
        check("d_stalled", DW'(stalled), DW'(1));

        cycle(1, 32'hD0D0_0004, 1);
        check("ret_cr",  DW'(credits),  DW'(1));
        check("ret_rdy", DW'(in_ready), DW'(1));
        check("ret_lv",  DW'(link_valid), DW'(0));
        cycle(1, 32'hD0D0_0004, 0);
        check("d_lv", DW'(link_valid), DW'(1));
        check("d_ld", link_data, 32'hD0D0_0004);
        check("d_cr", DW'(credits), DW'(0));

        cycle(0, '0, 1);
        check("one_cr", DW'(credits), DW'(1));
        cycle(1, 32'hE0E0_0005, 1);
        check("both_cr", DW'(credits), DW'(1));
        check("both_ld", link_data, 32'hE0E0_0005);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        check("full_cr",  DW'(credits),    DW'(3));
        check("full_err", DW'(credit_err), DW'(0));
        cycle(0, '0, 1);
        check("ovf_cr",  DW'(credits),    DW'(3));
        check("ovf_err", DW'(credit_err), DW'(1));
        cycle(1, 32'hF0F0_0006, 1);
        check("nz_cr",  DW'(credits), DW'(3));
        check("nz_ld",  link_data, 32'hF0F0_0006);
        cycle(0, '0, 0);
        check("sticky_err", DW'(credit_err), DW'(1));

        // mixed traffic pattern, checked by the model
        for (int i = 0; i < 24; i++)
            cycle(i % 3 != 2, DW'(32'h1000 + i), i % 4 == 1);

        // drain to 3 credits, then reach credits=1 with a flit on the link
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        check("pre_cr", DW'(credits), DW'(3));
        cycle(1, 32'h6000_0007, 0);
        cycle(1, 32'h7000_0008, 0);
        check("pre_rst_lv", DW'(link_valid), DW'(1));
        check("pre_rst_cr", DW'(credits), DW'(1));
        #2 reset = 1'b1;
        #1;
        check("arst_lv",  DW'(link_valid), DW'(0));
        check("arst_ld",  link_data,       DW'(0));
        check("arst_cr",  DW'(credits),    DW'(3));
        check("arst_rdy", DW'(in_ready),   DW'(1));
        check("arst_err", DW'(credit_err), DW'(0));
        in_valid      = 1'b0;
        credit_return = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        cycle(1, 32'h8000_0009, 0);
        check("post_ld", link_data, 32'h8000_0009);
        check("post_cr", DW'(credits), DW'(2));
        cycle(0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
